// File: rtl/spi_burst_pkg.sv
// Shared types and constants for the SPI burst engine: FSM states, register map, status layout.
package spi_burst_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_TX     = 3'd1;
    localparam logic [2:0] REG_RX     = 3'd2;
    localparam logic [2:0] REG_CMD    = 3'd3;
    localparam logic [2:0] REG_CLR    = 3'd4;

    localparam int ST_BUSY_BIT    = 0;
    localparam int ST_TXFULL_BIT  = 1;
    localparam int ST_TXEMPTY_BIT = 2;
    localparam int ST_RXFULL_BIT  = 3;
    localparam int ST_RXEMPTY_BIT = 4;
    localparam int ST_OVF_BIT     = 5;
    localparam int ST_DONE_BIT    = 6;
    localparam int ST_REM_LSB     = 8;
    localparam int ST_TXCNT_LSB   = 16;
    localparam int ST_RXCNT_LSB   = 24;

    localparam logic [7:0] FILL_BYTE = 8'hFF;

endpackage

// File: rtl/spi_burst_engine_fifo.sv
// Synchronous FIFO with combinational head; push/pop take effect on the next edge.
// Push while full is dropped (even with a simultaneous pop); pop while empty is ignored.
module sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_dat,
    input  logic          i_pop,
    output logic [DW-1:0] o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push_ok && !i_flush)
            r_mem[r_wr_ptr] <= i_push_dat;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push_ok && !w_pop_ok)      r_count <= r_count + (AW+1)'(1);
            else if (w_pop_ok && !w_push_ok) r_count <= r_count - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/spi_burst_engine.sv
// Sequences multi-byte SPI bursts from a TX FIFO into the byte-level SPI controller, RX bytes into an RX FIFO.
// Start issued 2 cycles after the command at earliest; stalls on spi_ready; optional irq with SPI_BURST_IRQ_EN.
module spi_burst_engine
    import spi_burst_pkg::*;
#(
    parameter int S      = 2,
    parameter int FIFO_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_cs,
    input  logic          i_read,
    input  logic          i_write,
    input  logic [4:0]    i_addr,
    input  logic [31:0]   i_wr_data,
    output logic [31:0]   o_rd_data,
    output logic [7:0]    o_spi_din,
    output logic          o_spi_start,
    input  logic [7:0]    i_spi_dout,
    input  logic          i_spi_done_tick,
    input  logic          i_spi_ready,
    output logic [S-1:0]  o_spi_ss_n,
    output logic          o_irq
);
    state_t          r_state, w_next;
    logic [8:0]      r_remaining;
    logic            r_keep, r_ovf, r_done;
    logic [S-1:0]    r_ss_n, w_ss_sel_n;
    logic            w_wr, w_rd, w_cmd_acc, w_clr, w_flush;
    logic            w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_byte_done;
    logic [7:0]      w_tx_head, w_rx_head;
    logic            w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic [FIFO_W:0] w_tx_count, w_rx_count;
    logic [31:0]     w_status;
    logic            w_unused;

    assign w_wr      = i_cs && i_write;
    assign w_rd      = i_cs && i_read;
    assign w_cmd_acc = w_wr && (i_addr[2:0] == REG_CMD) && (r_state == S_IDLE);
    assign w_clr     = w_wr && (i_addr[2:0] == REG_CLR) && i_wr_data[0];
    assign w_flush   = w_wr && (i_addr[2:0] == REG_CLR) && i_wr_data[1] && (r_state == S_IDLE);
    assign w_tx_push = w_wr && (i_addr[2:0] == REG_TX);
    assign w_rx_pop  = w_rd && (i_addr[2:0] == REG_RX);
    assign w_rx_push = w_byte_done && r_keep;
    assign w_unused  = &{1'b0, i_addr[4:3], i_wr_data[31:17]};
    assign o_spi_ss_n = r_ss_n;

    sync_fifo #(.DW(8), .AW(FIFO_W)) u_tx_fifo (
        .clk(clk), .reset(reset), .i_flush(w_flush),
        .i_push(w_tx_push), .i_push_dat(i_wr_data[7:0]), .i_pop(w_tx_pop),
        .o_head(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty), .o_count(w_tx_count)
    );

    sync_fifo #(.DW(8), .AW(FIFO_W)) u_rx_fifo (
        .clk(clk), .reset(reset), .i_flush(w_flush),
        .i_push(w_rx_push), .i_push_dat(i_spi_dout), .i_pop(w_rx_pop),
        .o_head(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_count(w_rx_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        o_spi_start = 1'b0;
        o_spi_din   = 8'h00;
        w_tx_pop    = 1'b0;
        w_byte_done = 1'b0;
        unique case (r_state)
            S_IDLE:  if (w_cmd_acc) w_next = S_SETUP;
            S_SETUP: w_next = S_ISSUE;
            S_ISSUE: if (i_spi_ready) begin
                // An empty TX never stalls the burst; the fill byte goes out instead.
                o_spi_start = 1'b1;
                o_spi_din   = w_tx_empty ? FILL_BYTE : w_tx_head;
                w_tx_pop    = !w_tx_empty;
                w_next      = S_WAIT;
            end
            S_WAIT:  if (i_spi_done_tick) begin
                w_byte_done = 1'b1;
                w_next      = (r_remaining == 9'd1) ? S_HOLD : S_ISSUE;
            end
            S_HOLD:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Out-of-range slave index leaves every select deasserted.
    always_comb begin
        w_ss_sel_n = '1;
        for (int i = 0; i < S; i++)
            w_ss_sel_n[i] = (i_wr_data[15:8] != 8'(i));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_remaining <= '0;
            r_keep      <= 1'b0;
            r_ovf       <= 1'b0;
            r_done      <= 1'b0;
            r_ss_n      <= '1;
        end else begin
            if (w_cmd_acc) begin
                r_remaining <= (i_wr_data[7:0] == 8'd0) ? 9'd256 : {1'b0, i_wr_data[7:0]};
                r_keep      <= i_wr_data[16];
                r_ss_n      <= w_ss_sel_n;
            end else if (w_byte_done) begin
                r_remaining <= r_remaining - 9'd1;
            end
            if (r_state == S_HOLD) begin
                r_ss_n <= '1;
                r_done <= 1'b1;
            end else if (w_clr) begin
                r_done <= 1'b0;
            end
            if (w_rx_push && w_rx_full) r_ovf <= 1'b1;
            else if (w_clr)             r_ovf <= 1'b0;
        end
    end

`ifdef SPI_BURST_IRQ_EN
    logic r_irq, r_irq_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq      <= 1'b0;
            r_irq_mask <= 1'b0;
        end else begin
            if (w_cmd_acc) r_irq_mask <= i_wr_data[17];
            if (r_state == S_HOLD && !r_irq_mask) r_irq <= 1'b1;
            else if (w_clr)                       r_irq <= 1'b0;
        end
    end

    assign o_irq = r_irq;
`else
    assign o_irq = 1'b0;
`endif

    always_comb begin
        w_status                              = '0;
        w_status[ST_BUSY_BIT]                 = (r_state != S_IDLE);
        w_status[ST_TXFULL_BIT]               = w_tx_full;
        w_status[ST_TXEMPTY_BIT]              = w_tx_empty;
        w_status[ST_RXFULL_BIT]               = w_rx_full;
        w_status[ST_RXEMPTY_BIT]              = w_rx_empty;
        w_status[ST_OVF_BIT]                  = r_ovf;
        w_status[ST_DONE_BIT]                 = r_done;
        w_status[ST_REM_LSB +: 8]             = r_remaining[7:0];
        w_status[ST_TXCNT_LSB +: FIFO_W+1]    = w_tx_count;
        w_status[ST_RXCNT_LSB +: FIFO_W+1]    = w_rx_count;
        o_rd_data = '0;
        case (i_addr[2:0])
            REG_STATUS: o_rd_data = w_status;
            REG_RX:     o_rd_data = w_rx_empty ? 32'h0000_0100 : {24'h0, w_rx_head};
            default:    o_rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_spi_burst_engine.sv
// Randomized bench for spi_burst_engine with a queue-based reference model and a simple SPI controller model.
module tb_spi_burst_engine;
    localparam int S     = 2;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cs = 1'b0;
    logic         read = 1'b0;
    logic         write = 1'b0;
    logic [4:0]   addr = '0;
    logic [31:0]  wr_data = '0;
    logic [31:0]  rd_data;
    logic [7:0]   spi_din;
    logic         spi_start;
    logic [7:0]   spi_dout = '0;
    logic         spi_done_tick = 1'b0;
    logic         spi_ready = 1'b1;
    logic [S-1:0] spi_ss_n;
    logic         irq;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_tick_cyc = 0;
    int ss_rise_cyc = 0;
    bit slow = 1'b0;
    logic [7:0]   miso_xor = 8'h00;
    logic [7:0]   start_q[$];
    logic [S-1:0] ss_q[$];
    int           start_cyc_q[$];
    logic [S-1:0] prev_ss = '1;

    logic [7:0] m_tx[$];
    logic [7:0] m_rx[$];
    bit m_ovf = 1'b0;
    bit m_done = 1'b0;
    bit m_irq = 1'b0;

    spi_burst_engine #(.S(S), .FIFO_W(4)) dut (
        .clk(clk), .reset(reset),
        .i_cs(cs), .i_read(read), .i_write(write), .i_addr(addr),
        .i_wr_data(wr_data), .o_rd_data(rd_data),
        .o_spi_din(spi_din), .o_spi_start(spi_start), .i_spi_dout(spi_dout),
        .i_spi_done_tick(spi_done_tick), .i_spi_ready(spi_ready),
        .o_spi_ss_n(spi_ss_n), .o_irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (spi_start) begin
            start_q.push_back(spi_din);
            ss_q.push_back(spi_ss_n);
            start_cyc_q.push_back(cyc);
        end
        if (prev_ss != {S{1'b1}} && spi_ss_n == {S{1'b1}}) ss_rise_cyc = cyc;
        prev_ss = spi_ss_n;
    end

    // Byte-level controller: drops ready after a start, answers after a few cycles.
    initial begin : ctl
        logic [7:0] b;
        int d;
        forever begin
            @(negedge clk);
            if (spi_start && !reset) begin
                b = spi_din;
                d = slow ? 8 : int'($urandom_range(0, 3));
                @(posedge clk); #1 spi_ready = 1'b0;
                repeat (d) begin @(posedge clk); #1; end
                spi_done_tick = 1'b1;
                spi_dout      = b ^ miso_xor;
                last_tick_cyc = cyc;
                @(posedge clk); #1;
                spi_done_tick = 1'b0;
                spi_ready     = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = {2'($urandom), a}; wr_data = d;
        @(posedge clk); #1;
        cs = 1'b0; write = 1'b0; wr_data = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        cs = 1'b1; read = 1'b1; addr = {2'($urandom), a};
        #1 d = rd_data;
        @(posedge clk); #1;
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic tx_push(input logic [7:0] b);
        bus_write(3'd1, {24'h0, b});
        if (m_tx.size() < DEPTH) m_tx.push_back(b);
    endtask

    task automatic clear_flags();
        bus_write(3'd4, 32'h1);
        m_ovf = 1'b0; m_done = 1'b0; m_irq = 1'b0;
    endtask

    task automatic check_status(input string tag);
        logic [31:0] st, exp;
        exp        = '0;
        exp[1]     = (m_tx.size() == DEPTH);
        exp[2]     = (m_tx.size() == 0);
        exp[3]     = (m_rx.size() == DEPTH);
        exp[4]     = (m_rx.size() == 0);
        exp[5]     = m_ovf;
        exp[6]     = m_done;
        exp[20:16] = 5'(m_tx.size());
        exp[28:24] = 5'(m_rx.size());
        bus_read(3'd0, st);
        chk(tag, st, exp);
    endtask

    task automatic drain_rx();
        logic [31:0] d;
        while (m_rx.size() > 0) begin
            bus_read(3'd2, d);
            chk("rx_data", d, {24'h0, m_rx.pop_front()});
        end
        bus_read(3'd2, d);
        chk("rx_empty_read", d, 32'h100);
    endtask

    task automatic run_burst(input logic [7:0] len, input logic [7:0] idx, input logic keep, input logic mask);
        logic [7:0]   exp_din[$];
        logic [7:0]   b;
        logic [S-1:0] exp_ss;
        logic [31:0]  st;
        int n, base, wcyc, guard;
        n = (len == 8'd0) ? 256 : int'(len);
        for (int k = 0; k < n; k++) begin
            b = (m_tx.size() > 0) ? m_tx.pop_front() : 8'hFF;
            exp_din.push_back(b);
            if (keep) begin
                if (m_rx.size() < DEPTH) m_rx.push_back(b ^ miso_xor);
                else                     m_ovf = 1'b1;
            end
        end
        exp_ss = {S{1'b1}};
        if (int'(idx) < S) exp_ss[int'(idx)] = 1'b0;
        base = start_q.size();
        wcyc = cyc;
        bus_write(3'd3, {14'h0, mask, keep, idx, len});
        chk("ss_setup", 32'(spi_ss_n), 32'(exp_ss));
        bus_read(3'd0, st);
        chk("busy_setup", 32'(st[0]), 32'd1);
        guard = 0;
        do begin
            bus_read(3'd0, st);
            guard++;
        end while (st[0] && guard < 5000);
        chk("idle_after_burst", 32'(st[0]), 32'd0);
        m_done = 1'b1;
`ifdef SPI_BURST_IRQ_EN
        if (!mask) m_irq = 1'b1;
`endif
        chk("start_count", 32'(start_q.size() - base), 32'(n));
        for (int k = 0; k < n && base + k < start_q.size(); k++) begin
            chk("spi_din", 32'(start_q[base+k]), 32'(exp_din[k]));
            chk("ss_during", 32'(ss_q[base+k]), 32'(exp_ss));
        end
        if (start_q.size() > base)
            chk("first_start_cyc", 32'(start_cyc_q[base] - wcyc), 32'd2);
        if (int'(idx) < S)
            chk("ss_release_delay", 32'(ss_rise_cyc - last_tick_cyc), 32'd2);
        chk("ss_idle", 32'(spi_ss_n), 32'(2'b11));
        chk("irq", 32'(irq), 32'(m_irq));
    endtask

    initial begin : main
        logic [31:0] st;
        int np, base, guard;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ss", 32'(spi_ss_n), 32'(2'b11));
        chk("rst_start", 32'(spi_start), 32'd0);
        chk("rst_din", 32'(spi_din), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_status", rd_data, 32'h14);
        reset = 1'b0;
        @(posedge clk); #1;
        check_status("status_after_reset");
        bus_read(3'd2, st);
        chk("rx_read_empty", st, 32'h100);

        // Loopback two-byte burst on slave 1.
        miso_xor = 8'h00;
        tx_push(8'hA5);
        tx_push(8'h3C);
        run_burst(8'd2, 8'd1, 1'b1, 1'b0);
        check_status("status_t1");
        drain_rx();
        clear_flags();
        check_status("status_cleared");

        // Empty TX: fill bytes go out.
        miso_xor = 8'h0F;
        run_burst(8'd3, 8'd0, 1'b1, 1'b0);
        check_status("status_t2");
        drain_rx();

        // TX overfill, flush, then a burst longer than the queued data.
        for (int j = 0; j < 17; j++) tx_push(8'($urandom));
        check_status("status_tx_full");
        bus_write(3'd4, 32'h2);
        m_tx.delete(); m_rx.delete();
        check_status("status_flushed");
        for (int j = 0; j < 17; j++) tx_push(8'($urandom));
        run_burst(8'd17, 8'd3, 1'b0, 1'b0);
        check_status("status_t3");

        // RX overflow: fill to depth, then two more kept bytes.
        miso_xor = 8'($urandom);
        run_burst(8'd16, 8'd0, 1'b1, 1'b0);
        tx_push(8'($urandom));
        tx_push(8'($urandom));
        run_burst(8'd2, 8'd1, 1'b1, 1'b0);
        check_status("status_overflow");
        drain_rx();
        clear_flags();

        for (int it = 0; it < 8; it++) begin
            np = $urandom_range(0, 6);
            for (int j = 0; j < np; j++) tx_push(8'($urandom));
            miso_xor = 8'($urandom);
            run_burst(8'($urandom_range(1, 8)), 8'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'b0);
            check_status("status_rand");
            if (m_rx.size() > 8 || $urandom_range(0, 1) == 1) drain_rx();
            if ($urandom_range(0, 2) == 0) clear_flags();
        end
        drain_rx();

        // Length 0 encodes 256 bytes.
        run_burst(8'd0, 8'd0, 1'b0, 1'b0);
        check_status("status_len256");

`ifdef SPI_BURST_IRQ_EN
        clear_flags();
        run_burst(8'd1, 8'd0, 1'b0, 1'b0);
        clear_flags();
        chk("irq_cleared", 32'(irq), 32'(m_irq));
        run_burst(8'd1, 8'd1, 1'b0, 1'b1);
`endif

        // Reset in the middle of a byte; command while busy is ignored.
        slow = 1'b1;
        tx_push(8'h11);
        tx_push(8'h22);
        base = start_q.size();
        bus_write(3'd3, {16'h0001, 8'd0, 8'd5});
        guard = 0;
        while (start_q.size() == base && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("start_before_reset", 32'(start_q.size() - base), 32'd1);
        bus_read(3'd0, st);
        chk("rem_in_wait", 32'(st[15:8]), 32'd5);
        bus_write(3'd3, {16'h0001, 8'd1, 8'd9});
        bus_read(3'd0, st);
        chk("rem_after_busy_cmd", 32'(st[15:8]), 32'd5);
        chk("ss_after_busy_cmd", 32'(spi_ss_n), 32'(2'b10));
        addr  = 5'd0;
        reset = 1'b1;
        #1;
        chk("midrst_ss", 32'(spi_ss_n), 32'(2'b11));
        chk("midrst_status", rd_data, 32'h14);
        chk("midrst_start", 32'(spi_start), 32'd0);
        @(posedge clk); #1;
        chk("midrst_status_next", rd_data, 32'h14);
        reset = 1'b0;
        m_tx.delete(); m_rx.delete();
        m_ovf = 1'b0; m_done = 1'b0; m_irq = 1'b0;
        slow = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_status("status_post_reset");

        miso_xor = 8'h00;
        tx_push(8'h5A);
        run_burst(8'd1, 8'd1, 1'b1, 1'b0);
        check_status("status_final");
        drain_rx();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
